vga_sync_recovery: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: samples external active-low hsync/vsync
//  (pixel-clock domain, asynchronous phase), measures line/frame lengths, locks after stable

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_edge_detect.sv | 90 +++++++++
 rtl/vga_sync_recovery.sv | 194 +++++++++++++++++++
 tb/tb_vga_sync_recovery.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants, counter widths, FSM state type and a saturating
// increment helper for the VGA sync-recovery block.
// Configuration macro: SYNC_POLARITY_DETECT_EN (enables the per-input level
// counters in sync_edge_detect, which size themselves with LEVEL_CNT_W).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   // Default 640x480 source timing.
   localparam int DEF_H_TOTAL       = 800;
   localparam int DEF_V_TOTAL       = 521;
   localparam int DEF_HSYNC_START_X = 657;
   localparam int DEF_VSYNC_START_Y = 491;
   localparam int DEF_X_RES         = 640;
   localparam int DEF_Y_RES         = 480;

   localparam int RASTER_W    = 10;
   localparam int MEAS_W      = 11;
   // A vsync period spans a whole frame of clocks.
   localparam int LEVEL_CNT_W = $clog2(DEF_H_TOTAL * DEF_V_TOTAL + 1);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   function automatic logic [MEAS_W-1:0] meas_inc(input logic [MEAS_W-1:0] v);
      return (v == {MEAS_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous active-low sync input into the clk domain and
// produces a one-clock pulse on its falling (asserting) edge.
// Configuration macro: SYNC_POLARITY_DETECT_EN -- when defined, the low and
// high times of each period are compared and the input is inverted when low
// dominates, so an active-high sync is still edge-detected on assertion.
// Ports:
//   clk       in   pixel clock
//   reset     in   asynchronous, active-high
//   sync_in   in   raw sync pin
//   fall_o    out  one-clock pulse on sync assertion
//   pol_chg_o out  one-clock pulse when the detected polarity flips
// ---------------------------------------------------------------------------
module sync_edge_detect
   import vga_timing_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sync_in,
   output logic fall_o,
   output logic pol_chg_o
);

   localparam int LAST = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   lvl;

   // Idle level of an active-low sync is high, so reset to 1 to avoid a
   // spurious fall when reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sync_in};
         hist_q <= sync_q[LAST];
      end
   end

   assign lvl = sync_q[LAST];

`ifdef SYNC_POLARITY_DETECT_EN
   logic                   inv_q, inv_d;
   logic                   raw_fall;
   logic [LEVEL_CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;

   assign raw_fall = hist_q & ~lvl;

   // A raw 1->0 transition closes one full period (one low run followed by
   // one high run); the new low run starts counting in this very clock.
   always_comb begin
      inv_d = inv_q;
      lo_d  = lo_q;
      hi_d  = hi_q;
      if (raw_fall) begin
         inv_d = (lo_q > hi_q);
         lo_d  = LEVEL_CNT_W'(1);
         hi_d  = '0;
      end else if (lvl) begin
         if (hi_q != '1) hi_d = hi_q + 1'b1;
      end else begin
         if (lo_q != '1) lo_d = lo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inv_q <= 1'b0;
         lo_q  <= '0;
         hi_q  <= '0;
      end else begin
         inv_q <= inv_d;
         lo_q  <= lo_d;
         hi_q  <= hi_d;
      end
   end

   assign fall_o    = (hist_q ^ inv_q) & ~(lvl ^ inv_q);
   assign pol_chg_o = (inv_d != inv_q);
`else
   assign fall_o    = hist_q & ~lvl;
   assign pol_chg_o = 1'b0;
`endif

endmodule

// File: rtl/vga_sync_recovery.sv
// ---------------------------------------------------------------------------
// vga_sync_recovery
// Recovers raster timing from external active-low hsync/vsync: measures the
// line and frame lengths, locks after LOCK_FRAMES consecutive matching
// frames and regenerates raster_x/raster_y/active for downstream capture.
// Raster coordinates trail the source counters by SYNC_STAGES+1 clocks.
// Configuration macro: SYNC_POLARITY_DETECT_EN (automatic sync polarity
// detection; a polarity flip forces SEARCH). Undefined: fixed active-low.
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous, active-high
//   hsync_in     in   external hsync (async)
//   vsync_in     in   external vsync (async)
//   raster_x     out  recovered column
//   raster_y     out  recovered line
//   active       out  locked and inside the visible area
//   locked       out  timing stable
//   frame_start  out  locked and raster at (0,0)
//   h_total      out  measured clocks per line (saturating)
//   v_total      out  measured lines per frame (saturating)
// ---------------------------------------------------------------------------
module vga_sync_recovery
   import vga_timing_pkg::*;
#(
   parameter int X_RES         = DEF_X_RES,
   parameter int Y_RES         = DEF_Y_RES,
   parameter int HSYNC_START_X = DEF_HSYNC_START_X,
   parameter int VSYNC_START_Y = DEF_VSYNC_START_Y,
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_FRAMES   = 2,
   parameter int H_TIMEOUT     = 2 * DEF_H_TOTAL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                hsync_in,
   input  logic                vsync_in,
   output logic [RASTER_W-1:0] raster_x,
   output logic [RASTER_W-1:0] raster_y,
   output logic                active,
   output logic                locked,
   output logic                frame_start,
   output logic [MEAS_W-1:0]   h_total,
   output logic [MEAS_W-1:0]   v_total
);

   localparam int MATCH_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   logic h_fall, v_fall, h_pol_chg, v_pol_chg;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_hsync (
      .clk       (clk),
      .reset     (reset),
      .sync_in   (hsync_in),
      .fall_o    (h_fall),
      .pol_chg_o (h_pol_chg)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
      .clk       (clk),
      .reset     (reset),
      .sync_in   (vsync_in),
      .fall_o    (v_fall),
      .pol_chg_o (v_pol_chg)
   );

   state_e               state_q, state_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic [RASTER_W-1:0]  x_q, x_d, y_q, y_d;
   logic [MEAS_W-1:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [MEAS_W-1:0]    h_total_q, h_total_d, v_total_q, v_total_d;
   logic                 line_bad_q, line_bad_d;
   logic                 locked_q;
   logic                 line_adv;
   logic [MEAS_W-1:0]    h_len, v_len;
   logic                 timeout, measuring, frame_ok;

   // Length of the line that ends on this h fall, and of the frame that ends
   // on this v fall (an h fall in the same clock still belongs to it).
   assign h_len     = meas_inc(hcnt_q);
   assign v_len     = h_fall ? meas_inc(vcnt_q) : vcnt_q;
   assign timeout   = !h_fall && (hcnt_q == MEAS_W'(H_TIMEOUT - 1));
   assign measuring = (state_q != LOCKED);
   assign frame_ok  = (v_len == v_total_q) && !line_bad_q;

   // Raster counters and measurement.
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      line_adv   = 1'b0;
      hcnt_d     = meas_inc(hcnt_q);
      vcnt_d     = v_len;
      h_total_d  = h_total_q;
      v_total_d  = v_total_q;
      line_bad_d = line_bad_q;

      // The sync load takes priority over the natural wrap.
      if (h_fall) begin
         x_d = RASTER_W'(HSYNC_START_X);
      end else if ((h_total_q != '0) && ({1'b0, x_q} == h_total_q - 1'b1)) begin
         x_d      = '0;
         line_adv = 1'b1;
      end else if (x_q != '1) begin
         x_d = x_q + 1'b1;
      end

      if (v_fall) begin
         y_d = RASTER_W'(VSYNC_START_Y);
      end else if (line_adv) begin
         if ((v_total_q != '0) && ({1'b0, y_q} == v_total_q - 1'b1)) begin
            y_d = '0;
         end else if (y_q != '1) begin
            y_d = y_q + 1'b1;
         end
      end

      if (h_fall || timeout) hcnt_d = '0;
      if (v_fall)            vcnt_d = '0;

      if (h_fall) begin
         if (h_len != h_total_q) line_bad_d = 1'b1;
         if (measuring)          h_total_d  = h_len;
      end
      if (v_fall) begin
         line_bad_d = 1'b0;
         if (measuring) v_total_d = v_len;
      end
   end

   // Lock FSM.
   always_comb begin
      state_d = state_q;
      match_d = match_q;
      case (state_q)
         SEARCH: begin
            if (v_fall) begin
               state_d = MEASURE;
               match_d = '0;
            end
         end
         MEASURE: begin
            if (v_fall) begin
               if (frame_ok) begin
                  match_d = match_q + 1'b1;
                  if (match_q + 1'b1 == MATCH_W'(LOCK_FRAMES)) state_d = LOCKED;
               end else begin
                  match_d = '0;
               end
            end
         end
         LOCKED: begin
            if ((h_fall && (h_len != h_total_q)) || (v_fall && (v_len != v_total_q))) begin
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase
      if (timeout || h_pol_chg || v_pol_chg) state_d = SEARCH;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SEARCH;
         match_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         h_total_q  <= '0;
         v_total_q  <= '0;
         line_bad_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         h_total_q  <= h_total_d;
         v_total_q  <= v_total_d;
         line_bad_q <= line_bad_d;
         locked_q   <= (state_q == LOCKED);
      end
   end

   assign raster_x    = x_q;
   assign raster_y    = y_q;
   assign locked      = locked_q;
   assign h_total     = h_total_q;
   assign v_total     = v_total_q;
   assign active      = locked_q && (x_q < RASTER_W'(X_RES)) && (y_q < RASTER_W'(Y_RES));
   assign frame_start = locked_q && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_vga_sync_recovery.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_recovery
// Directed bench on a reduced raster: 40 clocks x 20 lines, hsync low for
// x=30..34, vsync low for line 15, visible area 24x12, timeout 80 clocks.
// The DUT raster must equal the source counters delayed by 3 clocks.
// ---------------------------------------------------------------------------
module tb_vga_sync_recovery;

   localparam int HT   = 40;
   localparam int VT   = 20;
   localparam int XR   = 24;
   localparam int YR   = 12;
   localparam int HS_X = 30;
   localparam int HS_W = 5;
   localparam int VS_Y = 15;
   localparam int TMO  = 80;
   localparam int FRM  = HT * VT;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync_in, vsync_in;
   logic [9:0] raster_x, raster_y;
   logic       active, locked, frame_start;
   logic [10:0] h_total, v_total;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   sx, sy;
   int   hx[4];
   int   hy[4];
   logic inv, suppress_h, stretch_req;

   always #5 clk = ~clk;

   vga_sync_recovery #(
      .X_RES        (XR),
      .Y_RES        (YR),
      .HSYNC_START_X(HS_X),
      .VSYNC_START_Y(VS_Y),
      .SYNC_STAGES  (2),
      .LOCK_FRAMES  (2),
      .H_TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .raster_x   (raster_x),
      .raster_y   (raster_y),
      .active     (active),
      .locked     (locked),
      .frame_start(frame_start),
      .h_total    (h_total),
      .v_total    (v_total)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_pins();
      hsync_in = (!((sx >= HS_X) && (sx < HS_X + HS_W) && !suppress_h)) ^ inv;
      vsync_in = (!(sy == VS_Y)) ^ inv;
   endtask

   // One clock: source advances just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (stretch_req && (sx == HT - 1) && (sy == 5)) begin
         sx = HT;
         stretch_req = 1'b0;
      end else if (sx >= HT - 1) begin
         sx = 0;
         sy = (sy == VT - 1) ? 0 : sy + 1;
      end else begin
         sx = sx + 1;
      end
      for (int i = 3; i > 0; i--) begin
         hx[i] = hx[i-1];
         hy[i] = hy[i-1];
      end
      hx[0] = sx;
      hy[0] = sy;
      drive_pins();
   endtask

   task automatic step(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_xy(input string tag, input int x, input int y, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!((sx == x) && (sy == y)) && (n < budget));
      check(tag, sx * 100 + sy, x * 100 + y);
   endtask

   task automatic wait_lock(input string tag, input int budget);
      int n = 0;
      while (!locked && (n < budget)) begin
         tick();
         n++;
      end
      check(tag, int'(locked), 1);
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      sx          = 0;
      sy          = 0;
      suppress_h  = 1'b0;
      stretch_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hx[i] = 0;
         hy[i] = 0;
      end
      drive_pins();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_x"},      int'(raster_x),    0);
      check({pfx, "_y"},      int'(raster_y),    0);
      check({pfx, "_active"}, int'(active),      0);
      check({pfx, "_locked"}, int'(locked),      0);
      check({pfx, "_fs"},     int'(frame_start), 0);
      check({pfx, "_htot"},   int'(h_total),     0);
      check({pfx, "_vtot"},   int'(v_total),     0);
   endtask

   // From reset: 1st v fall enters MEASURE with a short v_total (15 lines),
   // 2nd mismatches and learns 20, 3rd and 4th match -> LOCKED on the 4th.
   // locked follows one clock after the state.
   task automatic lock_seq(input string pfx);
      for (int f = 0; f < 4; f++) wait_xy({pfx, "_vfall"}, 0, VS_Y, FRM + 10);
      step(3);
      check({pfx, "_not_early"}, int'(locked), 0);
      step(1);
      check({pfx, "_rise"}, int'(locked), 1);
      check({pfx, "_htot"}, int'(h_total), HT);
      check({pfx, "_vtot"}, int'(v_total), VT);
   endtask

   task automatic track_raster(input string tag, input int n, input int xoff, input bit chk_y);
      int bad = 0;
      repeat (n) begin
         tick();
         if (int'(raster_x) != (hx[3] + xoff + HT) % HT) bad++;
         if (chk_y && (int'(raster_y) != hy[3])) bad++;
      end
      check(tag, bad, 0);
   endtask

   initial begin
      int fs_n, fs_org, act_n;
      inv         = 1'b0;
      suppress_h  = 1'b0;
      stretch_req = 1'b0;
      sx          = 0;
      sy          = 0;
      for (int i = 0; i < 4; i++) begin
         hx[i] = 0;
         hy[i] = 0;
      end
      reset = 1'b1;
      drive_pins();
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst");
      apply_reset();

      // Clean stream: lock and raster tracking.
      lock_seq("lock");
      track_raster("raster_track", 200, 0, 1'b1);

      // One full frame of locked output.
      fs_n   = 0;
      fs_org = 0;
      act_n  = 0;
      repeat (FRM) begin
         tick();
         if (frame_start) begin
            fs_n++;
            if ((raster_x == 0) && (raster_y == 0)) fs_org++;
         end
         if (active) act_n++;
      end
      check("fs_count",  fs_n,   1);
      check("fs_origin", fs_org, 1);
      check("active_count", act_n, XR * YR);

      // Stretch line 5 to 41 clocks: the h fall on line 6 drops lock.
      wait_xy("to_top", 0, 0, FRM + 10);
      stretch_req = 1'b1;
      wait_xy("to_stretch_fall", HS_X, 6, FRM + 10);
      step(3);
      check("stretch_hold", int'(locked), 1);
      step(1);
      check("stretch_drop", int'(locked), 0);
      for (int f = 0; f < 3; f++) wait_xy("stretch_vfall", 0, VS_Y, FRM + 10);
      step(3);
      check("stretch_not_early", int'(locked), 0);
      step(1);
      check("stretch_relock", int'(locked), 1);

      // Missing hsync: last fall is 3 clocks before suppression starts.
      wait_xy("to_sync_end", HS_X + HS_W, 3, FRM + 10);
      suppress_h = 1'b1;
      drive_pins();
      step(60);
      check("tmo_hold", int'(locked), 1);
      step(40);
      check("tmo_drop", int'(locked), 0);
      check("tmo_active", int'(active), 0);
      suppress_h = 1'b0;
      wait_lock("tmo_relock", 6 * FRM);
      track_raster("tmo_raster", 100, 0, 1'b1);

      // Reset in the middle of a frame.
      wait_xy("to_mid", 13, 8, FRM + 10);
      check("mid_x", int'(raster_x), 10);
      check("mid_y", int'(raster_y), 8);
      #2;
      reset = 1'b1;
      #1;
      check_zero("midrst");
      apply_reset();
      lock_seq("relock");
      track_raster("relock_raster", 100, 0, 1'b1);

      // Inverted-polarity stream.
      inv = 1'b1;
      apply_reset();
      wait_lock("inv_lock", 8 * FRM);
`ifdef SYNC_POLARITY_DETECT_EN
      track_raster("inv_raster", 100, 0, 1'b0);
`else
      track_raster("inv_raster", 100, -HS_W, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
